hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. Sits beside the decode stage and drives the write enables of the PC, the fetch/decode boundary and the decode/execute boundary (the `we` and `stall` inputs of the decode stage). It resolves four conditions:
- load-use hazards
- read-after-write on results still in flight in the multi-cycle multiplier pipeline
- register-file write-port collisions between multiplier and ALU results
- data-memory freezes

It also squashes the wrong-path fetch slot after a jump.

## Interface
Parameters:
- MULT_LAT, 5, cycles from multiplier issue (D→EX edge) to its register-file write; must exceed ALU_LAT
- ALU_LAT, 3, cycles from non-mult issue to its register-file write
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_src_reg1  in  5  decode source register 1
- id_src_reg2  in  5  decode source register 2
- id_uses_reg2  in  1  instruction reads src_reg2
- id_dest_reg  in  5  decode destination register
- id_regwrite  in  1  instruction writes the register file
- id_is_mult  in  1  instruction is the R-type multiply
- id_is_jump  in  1  decode holds a jump (asynchronous jump signal)
- ex_memread  in  1  instruction in EX is a load
- ex_dest_reg  in  5  destination of instruction in EX
- mem_busy  in  1  data memory not ready; the back end freezes
- pc_we  out  1  PC update enable
- fd_we  out  1  fetch/decode boundary write enable
- fd_flush  out  1  load a NOP into the fetch/decode boundary
- de_we  out  1  decode/execute boundary write enable (decode `we`)
- stall  out  1  inject bubble: control signals zeroed (decode `stall`)
- mul_issue  out  1  multiply issued to EX this cycle
- state  out  2  0=RUN, 1=HOLD, 2=FREEZE
- stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0

## Operation
- Scoreboard: MULT_LAT slots, each holding a valid bit and a 5-bit destination.
  - Slot 0 is filled on multiply issue.
  - On every non-frozen edge, every slot shifts up by one; slot MULT_LAT-1 drops off.
  - The entry in slot MULT_LAT-1 is writing back during that cycle.
- Hazard terms (evaluated combinationally, only when id_valid=1):
  - loaduse = ex_memread & ex_dest_reg≠0 & (ex_dest_reg==id_src_reg1 | id_uses_reg2 & ex_dest_reg==id_src_reg2)
  - mulraw = any valid scoreboard slot with dest≠0 matching id_src_reg1, or matching id_src_reg2 when id_uses_reg2. The register file has no write-through bypass, so slot MULT_LAT-1 also counts.
  - wbconf = id_regwrite & ~id_is_mult & valid[MULT_LAT-ALU_LAT-1]
  - hazard = loaduse | mulraw | wbconf
- Per-cycle decision, in priority order:
  1. mem_busy=1:
     - pc_we=fd_we=de_we=0, stall=0, fd_flush=0.
     - Scoreboard held; next state FREEZE.
  2. hazard=1:
     - pc_we=fd_we=0, de_we=1, stall=1.
     - Scoreboard shifts in an empty slot 0; next state HOLD.
  3. id_is_jump=1 (with id_valid=1):
     - pc_we=fd_we=de_we=1, fd_flush=1, stall=0.
     - Next state RUN.
  4. Otherwise:
     - pc_we=fd_we=de_we=1, stall=0, fd_flush=0.
     - Next state RUN.
- In cases 3 and 4:
  - mul_issue = id_valid & id_is_mult & id_regwrite.
  - On issue, slot 0 takes id_dest_reg; otherwise slot 0 is empty.
- State is informational: outputs depend only on inputs and scoreboard, not on state. Transitions are exactly the next-state values listed above from every state.
- stall_cnt increments on each edge where pc_we=0; it holds at all-ones.

## Timing
- All decisions are combinational in the same cycle. Scoreboard, state and stall_cnt update on the rising edge.
- A load-use hazard costs exactly one bubble. At the next edge the load leaves EX and loaduse drops.
- A multiply RAW stalls until the producer's slot drops out of MULT_LAT-1. Its consumer issues on the cycle after the writeback cycle.
- A write-port conflict costs one bubble.
- Simultaneous mem_busy and hazard: freeze wins, scoreboard does not age, and the hazard is re-evaluated afterwards.
- Simultaneous jump and hazard: hazard wins, so the jump is held in decode and no flush occurs. The flush happens on the cycle the jump issues.
- id_valid=0: no hazard terms, no issue; the slot passes as in case 4.
- Reset low, at any time and asynchronously:
  - scoreboard cleared, state=RUN, stall_cnt=0
  - pc_we=fd_we=de_we=0, stall=1, fd_flush=0, mul_issue=0
- Normal operation starts on the first edge after reset rises.

## Test plan
- Load-use: ex_memread=1, ex_dest_reg=5, id_src_reg1=5 → one cycle with pc_we=0, stall=1, state=HOLD; next cycle pc_we=1; stall_cnt=1.
- Mult RAW: issue mult dest=7, then consumer reading r7 → pc_we=0 for 5 consecutive cycles; consumer issues on the 6th; no stall if consumer reads r0 with mult dest=0.
- Write-port conflict: mult dest=3 issued; two cycles later present an ADD with regwrite=1 to r9 → exactly one bubble (wbconf at slot 1).
- Jump: id_is_jump=1, no hazard → fd_flush=1 for one cycle, pc_we=1; with concurrent load-use, flush delayed one cycle.
- Freeze: mem_busy held 3 cycles during a mult RAW stall → all enables 0, state=FREEZE, scoreboard frozen; RAW stall resumes with the same remaining count.
- Reset mid-stall: assert reset during mult RAW → outputs go to reset values immediately; after release, consumer issues with no stall; stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Decode-side hazard controller: load-use, multiplier RAW, write-port conflict,
// memory freeze and post-jump squash, with a multiplier in-flight scoreboard.
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int ALU_LAT  = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_src_reg1,
  input  logic [4:0]       id_src_reg2,
  input  logic             id_uses_reg2,
  input  logic [4:0]       id_dest_reg,
  input  logic             id_regwrite,
  input  logic             id_is_mult,
  input  logic             id_is_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_dest_reg,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             fd_we,
  output logic             fd_flush,
  output logic             de_we,
  output logic             stall,
  output logic             mul_issue,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WB_SLOT = MULT_LAT - ALU_LAT - 1;

  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FREEZE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [MULT_LAT-1:0] sb_vld;
  logic [4:0]          sb_dst [MULT_LAT];
  logic                loaduse, mulraw, wbconf, hazard;

  function automatic logic reads(input logic [4:0] r, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic use2);
    return (r != 5'd0) && ((r == s1) || (use2 && (r == s2)));
  endfunction

  // No write-through in the register file, so the writeback slot still blocks.
  always_comb begin
    mulraw = 1'b0;
    for (int i = 0; i < MULT_LAT; i++) begin
      if (sb_vld[i] && reads(sb_dst[i], id_src_reg1, id_src_reg2, id_uses_reg2)) begin
        mulraw = 1'b1;
      end
    end
  end

  assign loaduse = ex_memread && reads(ex_dest_reg, id_src_reg1, id_src_reg2, id_uses_reg2);
  assign wbconf  = id_regwrite && !id_is_mult && sb_vld[WB_SLOT];
  assign hazard  = id_valid && (loaduse || mulraw || wbconf);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RUN;
    if (mem_busy) begin
      state_d = FREEZE;
    end else if (hazard) begin
      state_d = HOLD;
    end
  end

  always_comb begin
    pc_we     = 1'b0;
    fd_we     = 1'b0;
    de_we     = 1'b0;
    stall     = 1'b0;
    fd_flush  = 1'b0;
    mul_issue = 1'b0;
    if (!reset) begin
      stall = 1'b1;
    end else if (mem_busy) begin
      stall = 1'b0;
    end else if (hazard) begin
      de_we = 1'b1;
      stall = 1'b1;
    end else begin
      pc_we     = 1'b1;
      fd_we     = 1'b1;
      de_we     = 1'b1;
      fd_flush  = id_valid && id_is_jump;
      mul_issue = id_valid && id_is_mult && id_regwrite;
    end
  end

  assign state = state_q;

  // A freeze holds the scoreboard; a bubble shifts in an empty slot 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_vld    <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < MULT_LAT; i++) begin
        sb_dst[i] <= 5'd0;
      end
    end else begin
      if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!mem_busy) begin
        sb_vld    <= {sb_vld[MULT_LAT-2:0], mul_issue};
        sb_dst[0] <= id_dest_reg;
        for (int i = 1; i < MULT_LAT; i++) begin
          sb_dst[i] <= sb_dst[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl with a queue-based in-flight model.
module tb_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int ALU_LAT  = 3;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid, id_uses_reg2, id_regwrite, id_is_mult, id_is_jump;
  logic [4:0]       id_src_reg1, id_src_reg2, id_dest_reg, ex_dest_reg;
  logic             ex_memread, mem_busy;
  logic             pc_we, fd_we, fd_flush, de_we, stall, mul_issue;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.MULT_LAT(MULT_LAT), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_reg1(id_src_reg1),
    .id_src_reg2(id_src_reg2), .id_uses_reg2(id_uses_reg2), .id_dest_reg(id_dest_reg),
    .id_regwrite(id_regwrite), .id_is_mult(id_is_mult), .id_is_jump(id_is_jump),
    .ex_memread(ex_memread), .ex_dest_reg(ex_dest_reg), .mem_busy(mem_busy),
    .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush), .de_we(de_we), .stall(stall),
    .mul_issue(mul_issue), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, vld, u2, rw, mul, jmp, exm, busy;
    logic [4:0] s1, s2, d, exd;
  } stim_t;

  typedef struct {
    logic pc_we, fd_we, fd_flush, de_we, stall, mul_issue;
    logic [1:0] state;
    int unsigned cnt;
  } exp_t;

  // Each in-flight multiply: destination and edges elapsed since issue.
  typedef struct {
    logic [4:0] dst;
    int age;
  } flight_t;

  flight_t     fl[$];
  exp_t        expq[$];
  int unsigned m_cnt;
  logic [1:0]  m_state;
  stim_t       cur;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic rd(input stim_t s, input logic [4:0] r);
    return (r != 5'd0) && ((r == s.s1) || (s.u2 && (r == s.s2)));
  endfunction

  function automatic logic haz(input stim_t s);
    logic h;
    if (!s.vld) return 1'b0;
    h = s.exm && rd(s, s.exd);
    foreach (fl[i]) begin
      if (rd(s, fl[i].dst)) h = 1'b1;
      // An ALU result now would collide at the single write port with this multiply.
      if (s.rw && !s.mul && (fl[i].age == MULT_LAT - ALU_LAT)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic exp_t expect_of(input stim_t s);
    exp_t e;
    logic h;
    e = '{default: '0};
    e.state = m_state;
    e.cnt   = m_cnt;
    h = haz(s);
    if (!s.rst) begin
      e.stall = 1'b1;
    end else if (s.busy) begin
      e.stall = 1'b0;
    end else if (h) begin
      e.de_we = 1'b1;
      e.stall = 1'b1;
    end else begin
      e.pc_we     = 1'b1;
      e.fd_we     = 1'b1;
      e.de_we     = 1'b1;
      e.fd_flush  = s.vld && s.jmp;
      e.mul_issue = s.vld && s.mul && s.rw;
    end
    return e;
  endfunction

  task automatic model_clear();
    fl.delete();
    m_cnt   = 0;
    m_state = 2'd0;
  endtask

  task automatic model_edge(input stim_t s);
    flight_t nf[$];
    logic h;
    if (!s.rst) begin
      model_clear();
      return;
    end
    h = haz(s);
    if (s.busy || h) begin
      if (m_cnt < (2**CNT_W) - 1) m_cnt++;
    end
    if (s.busy) begin
      m_state = 2'd2;
      return;
    end
    m_state = h ? 2'd1 : 2'd0;
    foreach (fl[i]) begin
      if (fl[i].age + 1 <= MULT_LAT) nf.push_back('{fl[i].dst, fl[i].age + 1});
    end
    if (!h && s.vld && s.mul && s.rw) nf.push_back('{s.d, 1});
    fl = nf;
  endtask

  task automatic apply(input stim_t s);
    @(posedge clk);
    model_edge(cur);
    #1;
    cur          = s;
    reset        = s.rst;
    id_valid     = s.vld;
    id_src_reg1  = s.s1;
    id_src_reg2  = s.s2;
    id_uses_reg2 = s.u2;
    id_dest_reg  = s.d;
    id_regwrite  = s.rw;
    id_is_mult   = s.mul;
    id_is_jump   = s.jmp;
    ex_memread   = s.exm;
    ex_dest_reg  = s.exd;
    mem_busy     = s.busy;
    if (!s.rst) model_clear();
    expq.push_back(expect_of(s));
  endtask

  task automatic cnt_at(input string name, input int unsigned req);
    @(negedge clk);
    chk(name, stall_cnt, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pc_we", pc_we, e.pc_we);
        chk("fd_we", fd_we, e.fd_we);
        chk("fd_flush", fd_flush, e.fd_flush);
        chk("de_we", de_we, e.de_we);
        chk("stall", stall, e.stall);
        chk("mul_issue", mul_issue, e.mul_issue);
        chk("state", state, e.state);
        chk("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    stim_t idle, s, cons, mul7;
    idle = '{rst: 1'b1, default: '0};
    cur  = '{default: '0};
    model_clear();
    reset = 1'b0;
    {id_valid, id_uses_reg2, id_regwrite, id_is_mult, id_is_jump, ex_memread, mem_busy} = '0;
    {id_src_reg1, id_src_reg2, id_dest_reg, ex_dest_reg} = '0;

    s = idle; s.rst = 1'b0;
    apply(s); apply(s);
    apply(idle);

    // Load-use: one bubble.
    s = idle; s.vld = 1; s.s1 = 5; s.s2 = 1; s.rw = 1; s.d = 6; s.exm = 1; s.exd = 5;
    apply(s);
    s.exm = 0;
    apply(s);
    cnt_at("lu_cnt", 1);

    // Multiply RAW: five bubbles, consumer issues on the sixth cycle.
    mul7 = idle; mul7.vld = 1; mul7.mul = 1; mul7.rw = 1; mul7.d = 7; mul7.s1 = 1; mul7.s2 = 2;
    cons = idle; cons.vld = 1; cons.rw = 1; cons.d = 8; cons.s1 = 7; cons.s2 = 3; cons.u2 = 1;
    apply(mul7);
    for (int i = 0; i < 6; i++) apply(cons);
    cnt_at("raw_cnt", 6);

    // r0 never creates a dependency.
    s = mul7; s.d = 0;
    apply(s);
    s = idle; s.vld = 1; s.s1 = 0; s.s2 = 0; s.u2 = 1;
    apply(s);
    apply(idle);
    cnt_at("r0_cnt", 6);

    // Write-port conflict: ALU op two cycles behind a multiply.
    s = mul7; s.d = 3;
    apply(s);
    apply(idle);
    s = idle; s.vld = 1; s.rw = 1; s.d = 9; s.s1 = 1; s.s2 = 2; s.u2 = 1;
    apply(s); apply(s);
    apply(idle);
    cnt_at("wb_cnt", 7);

    // Jump alone, then jump blocked by load-use.
    s = idle; s.vld = 1; s.jmp = 1; s.s1 = 4;
    apply(s);
    s.exm = 1; s.exd = 4;
    apply(s);
    s.exm = 0;
    apply(s);
    apply(idle);
    cnt_at("jmp_cnt", 8);

    // Freeze in the middle of a multiply RAW stall.
    apply(mul7);
    apply(cons); apply(cons);
    s = cons; s.busy = 1;
    apply(s); apply(s); apply(s);
    for (int i = 0; i < 4; i++) apply(cons);
    apply(idle);
    cnt_at("frz_cnt", 16);

    // Asynchronous reset during a RAW stall.
    apply(mul7);
    apply(cons); apply(cons);
    s = cons; s.rst = 0;
    apply(s); apply(s);
    apply(cons);
    apply(idle);
    cnt_at("rst_cnt", 0);

    for (int n = 0; n < 3000; n++) begin
      s.rst  = ($urandom_range(199) != 0);
      s.vld  = ($urandom_range(9) != 0);
      s.s1   = 5'($urandom_range(7));
      s.s2   = 5'($urandom_range(7));
      s.u2   = 1'($urandom_range(1));
      s.d    = 5'($urandom_range(7));
      s.rw   = ($urandom_range(3) != 0);
      s.mul  = ($urandom_range(3) == 0);
      s.jmp  = ($urandom_range(7) == 0);
      s.exm  = ($urandom_range(3) == 0);
      s.exd  = 5'($urandom_range(7));
      s.busy = ($urandom_range(9) == 0);
      apply(s);
    end
    apply(idle);
    @(negedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
